lfsr_rng: RTL and testbench
===========================

Name: lfsr_rng

Overview:
- Parametrised Galois LFSR random source with a registered valid/ready output stage.
- Three output modes: raw uniform, bounded uniform in [0, limit) by rejection sampling, and approximate Gaussian (popcount of state).
- Supports runtime seeding, stall/enable, and lock-up recovery.
- Feeds game-logic consumers (spawn positions, timers) that need values on demand.

Parameters:
- WIDTH, 16, LFSR state width (4..32).
- TAPS, 16'hB400, Galois feedback mask. Default is maximal: x^16+x^14+x^13+x^11+1.
- SEED, 16'h0001, reset and fallback seed; must be nonzero.
- OUT_W, 8, output width; must satisfy OUT_W >= clog2(WIDTH+1) and OUT_W <= WIDTH.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  advance enable. 0 = LFSR and output stage frozen.
- seed_load  in  1  synchronous seed strobe.
- seed_in  in  WIDTH  seed value, sampled when seed_load=1.
- mode  in  2  0=UNIFORM, 1=BOUNDED, 2=GAUSS, 3=reserved (behaves as UNIFORM).
- limit  in  OUT_W  exclusive upper bound for BOUNDED. 0 = full range.
- out_valid  out  1  out_data holds a fresh value.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  OUT_W  random value.
- lockup_err  out  1  sticky flag: all-zero state was detected.

Behaviour:
- Reset (async, rst_n=0): state=SEED, out_valid=0, out_data=0, lockup_err=0.
- LFSR step (right-shifting Galois): next = (state>>1) ^ (state[0] ? TAPS : 0).
- Priority per edge: seed_load > lock-up recovery > en-step > hold.
- seed_load=1 (regardless of en):
  - state=seed_in, or SEED if seed_in==0.
  - out_valid cleared; out_data keeps its old value; lockup_err cleared.
  - Any pending value is discarded, so output is deterministic after seeding.
- Lock-up: if state==0 without seed_load, state reloads SEED and lockup_err sets (sticky until seed_load or reset). No output load occurs that cycle.
- en=1, no seed_load: state steps every cycle.
- Candidate is formed from the current (pre-step) state:
  - UNIFORM: state[OUT_W-1:0].
  - BOUNDED: state[OUT_W-1:0] & M, where M = (next power of two >= limit) - 1. Accept only if the value < limit. limit==0 always accepts, with M all-ones. limit==1 always yields 0.
  - GAUSS: popcount(state), range 0..WIDTH, zero-extended.
- Output load condition: en=1 && !seed_load && (!out_valid || out_ready) && candidate accepted.
  - On load: out_data=candidate, out_valid=1.
  - Back-to-back transfers allowed: one value per cycle while out_ready=1 and candidates accept.
- If the consumer takes a value and the candidate is rejected: out_valid=0 next cycle.
- out_valid=1 && out_ready=0: out_data and out_valid are stable. The LFSR still steps if en=1.
- mode/limit are sampled only at load. Changing them never alters a held value.
- Latency: first out_valid is 2 edges after seed_load (or 1 edge after reset release with en=1).
- Period with default TAPS: 65535 steps; state never reaches 0 in normal operation.

Decomposition:
- rng_pkg holds:
  - mode enum (RNG_UNIFORM, RNG_BOUNDED, RNG_GAUSS).
  - maximal-length tap constants for widths 8, 9, 16, 24, 32.
  - popcount and next-pow2-mask functions.
- Sub-module lfsr_core (WIDTH, TAPS, SEED): state register, step, seed load, lock-up recovery, lockup_err.
- lfsr_rng wraps lfsr_core and contains the candidate logic and output register.

Test Plan:
- Reset then seed_load seed_in=16'h0001, en=1, out_ready=1, mode=0 -> out_data sequence 01,00,00,00,80 on consecutive cycles, out_valid=1 from the 2nd edge.
- seed_in=0 -> state takes SEED=0001; same sequence as above; lockup_err=0.
- Hold out_ready=0 for 10 cycles after first valid -> out_data stays 01, out_valid=1. On release the next value is the low byte of the state at that cycle, not 00.
- mode=1, limit=3, 1000 accepted samples -> every out_data <= 2; all of 0, 1, 2 present; out_valid deasserts on rejected cycles.
- mode=2, seed 16'hFFFF -> first out_data=16. Over 65535 samples, the values 0 and 16 each occur at most once and the mean is about 8.
- Count steps from seed 0001 to the state returning to 0001 -> exactly 65535. Force state=0 via hierarchical deposit -> next edge state=0001, lockup_err=1; seed_load clears lockup_err.

Source files
------------

// File: rtl/rng_pkg.sv
// Shared types and helpers for the LFSR random source.
//   rng_mode_e     : output mode encoding (value 3 is treated as uniform)
//   TAPS_W*        : maximal-length masks for a right-shifting Galois LFSR.
//                    Polynomial term x^k maps to mask bit k-1.
//   popcount       : number of set bits in a 32-bit word
//   next_pow2_mask : (smallest power of two >= lim) - 1; an input of 0 yields all-ones
package rng_pkg;

  typedef enum logic [1:0] {
    RNG_UNIFORM = 2'd0,
    RNG_BOUNDED = 2'd1,
    RNG_GAUSS   = 2'd2
  } rng_mode_e;

  localparam logic [7:0]  TAPS_W8  = 8'hB8;          // x^8+x^6+x^5+x^4+1
  localparam logic [8:0]  TAPS_W9  = 9'h110;         // x^9+x^5+1
  localparam logic [15:0] TAPS_W16 = 16'hB400;       // x^16+x^14+x^13+x^11+1
  localparam logic [23:0] TAPS_W24 = 24'hE10000;     // x^24+x^23+x^22+x^17+1
  localparam logic [31:0] TAPS_W32 = 32'h80200003;   // x^32+x^22+x^2+x+1

  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] cnt;
    cnt = '0;
    for (int i = 0; i < 32; i++) cnt = cnt + 6'(v[i]);
    return cnt;
  endfunction

  // lim-1 with every bit below its leading one filled in. lim==0 wraps to all-ones.
  function automatic logic [31:0] next_pow2_mask(input logic [31:0] lim);
    logic [31:0] m;
    m = lim - 32'd1;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    m = m | (m >> 8);
    m = m | (m >> 16);
    return m;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Galois LFSR state register with seeding and lock-up recovery.
//   clk, rst_n  : clock, async active-low reset (state <= SEED)
//   en          : step the LFSR this cycle
//   seed_load   : load seed_in (SEED if seed_in is zero), clear lockup_err
//   seed_in     : seed value
//   state       : current LFSR state
//   lockup      : state is all-zero this cycle (recovery happens on this edge)
//   lockup_err  : sticky, set when an all-zero state was recovered
module lfsr_core #(
  parameter int              WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS = 16'hB400,
  parameter logic [WIDTH-1:0] SEED = 16'h0001
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] state,
  output logic             lockup,
  output logic             lockup_err
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] step;

  assign step   = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
  assign lockup = (state_q == '0);
  assign state  = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SEED;
      lockup_err <= 1'b0;
    end else if (seed_load) begin
      state_q    <= (seed_in == '0) ? SEED : seed_in;
      lockup_err <= 1'b0;
    end else if (lockup) begin
      // Zero is a fixed point of the LFSR; recover even when en is low.
      state_q    <= SEED;
      lockup_err <= 1'b1;
    end else if (en) begin
      state_q    <= step;
    end
  end

endmodule

// File: rtl/lfsr_rng.sv
// Random source: LFSR plus a valid/ready output register.
//   clk, rst_n  : clock, async active-low reset
//   en          : advance enable; 0 freezes the LFSR and the output stage
//   seed_load   : synchronous seed strobe; discards any pending output
//   seed_in     : seed value
//   mode        : 0 uniform, 1 bounded [0,limit), 2 popcount "gauss", 3 uniform
//   limit       : exclusive bound for bounded mode; 0 means full range
//   out_valid   : out_data holds a value not yet taken
//   out_ready   : consumer accepts out_data
//   out_data    : random value
//   lockup_err  : sticky all-zero-state flag
module lfsr_rng
  import rng_pkg::*;
#(
  parameter int              WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS = 16'hB400,
  parameter logic [WIDTH-1:0] SEED = 16'h0001,
  parameter int              OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic [1:0]       mode,
  input  logic [OUT_W-1:0] limit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             lockup_err
);

  logic [WIDTH-1:0] state;
  logic             lockup;
  logic [OUT_W-1:0] cand;
  logic [OUT_W-1:0] bnd_mask;
  logic             accept;
  logic             load;

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .seed_load  (seed_load),
    .seed_in    (seed_in),
    .state      (state),
    .lockup     (lockup),
    .lockup_err (lockup_err)
  );

  // Candidate comes from the pre-step state, so it is the value that was
  // visible before this edge.
  always_comb begin
    cand     = state[OUT_W-1:0];
    accept   = 1'b1;
    bnd_mask = OUT_W'(next_pow2_mask(32'(limit)));
    case (mode)
      RNG_BOUNDED: begin
        cand   = state[OUT_W-1:0] & bnd_mask;
        accept = (limit == '0) || (cand < limit);
      end
      RNG_GAUSS: begin
        cand = OUT_W'(popcount(32'(state)));
      end
      default: begin
        cand = state[OUT_W-1:0];
      end
    endcase
  end

  assign load = en && !seed_load && !lockup && (!out_valid || out_ready) && accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (seed_load) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= cand;
    end else if (en && out_ready) begin
      // Value taken but nothing new to replace it this cycle.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lfsr_rng.sv
module tb_lfsr_rng;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        seed_load;
  logic [15:0] seed_in;
  logic [1:0]  mode;
  logic [7:0]  limit;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        lockup_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lfsr_rng u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .seed_load  (seed_load),
    .seed_in    (seed_in),
    .mode       (mode),
    .limit      (limit),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .lockup_err (lockup_err)
  );

  typedef struct {
    logic        sl;
    logic [15:0] si;
    logic        en;
    logic [1:0]  mode;
    logic [7:0]  lim;
    logic        rdy;
    logic        ev;
    logic [7:0]  ed;
    logic        el;
  } vec_t;

  vec_t tbl [25];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sl, input logic [15:0] si, input logic e,
                       input logic [1:0] m, input logic [7:0] l, input logic r);
    seed_load = sl; seed_in = si; en = e; mode = m; limit = l; out_ready = r;
  endtask

  initial begin
    int accepted, cyc, bad_range, first_valid, saw_reject;
    int seen [3];
    int steps, cnt0, cnt16;
    longint sum;

    rst_n = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 2'd0, 8'h0, 1'b0);
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'h00);
    chk("rst_lock", 32'(lockup_err), 32'd0);
    chk("rst_state", 32'(u_dut.u_core.state_q), 32'h0001);
    rst_n = 1'b1;
    tick();

    //           sl  seed      en  mode  lim    rdy  ev    ed     el
    tbl[0]  = '{1'b1, 16'h0001, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[1]  = '{1'b0, 16'h0000, 1'b1, 2'd0, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0};
    tbl[2]  = '{1'b0, 16'h0000, 1'b1, 2'd0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
    tbl[3]  = '{1'b0, 16'h0000, 1'b1, 2'd0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
    tbl[4]  = '{1'b0, 16'h0000, 1'b1, 2'd0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
    tbl[5]  = '{1'b0, 16'h0000, 1'b1, 2'd0, 8'h00, 1'b1, 1'b1, 8'h80, 1'b0};
    tbl[6]  = '{1'b1, 16'h0000, 1'b1, 2'd0, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0};
    tbl[7]  = '{1'b0, 16'h0000, 1'b1, 2'd0, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0};
    tbl[8]  = '{1'b0, 16'h0000, 1'b1, 2'd0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
    tbl[9]  = '{1'b0, 16'h0000, 1'b1, 2'd0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
    tbl[10] = '{1'b0, 16'h0000, 1'b1, 2'd0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
    tbl[11] = '{1'b0, 16'h0000, 1'b1, 2'd0, 8'h00, 1'b1, 1'b1, 8'h80, 1'b0};
    tbl[12] = '{1'b0, 16'h0000, 1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 8'h80, 1'b0};
    tbl[13] = '{1'b0, 16'h0000, 1'b1, 2'd1, 8'h01, 1'b1, 1'b1, 8'h00, 1'b0};
    tbl[14] = '{1'b0, 16'h0000, 1'b1, 2'd1, 8'h00, 1'b1, 1'b1, 8'hA0, 1'b0};
    tbl[15] = '{1'b0, 16'h0000, 1'b1, 2'd2, 8'h00, 1'b1, 1'b1, 8'h04, 1'b0};
    tbl[16] = '{1'b0, 16'h0000, 1'b1, 2'd3, 8'h00, 1'b1, 1'b1, 8'h68, 1'b0};
    tbl[17] = '{1'b0, 16'h0000, 1'b1, 2'd1, 8'h20, 1'b1, 1'b1, 8'h14, 1'b0};
    tbl[18] = '{1'b0, 16'h0000, 1'b1, 2'd1, 8'h05, 1'b1, 1'b1, 8'h02, 1'b0};
    tbl[19] = '{1'b0, 16'h0000, 1'b1, 2'd1, 8'h05, 1'b1, 1'b0, 8'h02, 1'b0};
    tbl[20] = '{1'b0, 16'h0000, 1'b1, 2'd1, 8'h05, 1'b1, 1'b0, 8'h02, 1'b0};
    tbl[21] = '{1'b0, 16'h0000, 1'b1, 2'd0, 8'h00, 1'b1, 1'b1, 8'h0B, 1'b0};
    tbl[22] = '{1'b0, 16'h0000, 1'b1, 2'd0, 8'h00, 1'b0, 1'b1, 8'h0B, 1'b0};
    tbl[23] = '{1'b0, 16'h0000, 1'b1, 2'd1, 8'h01, 1'b0, 1'b1, 8'h0B, 1'b0};
    tbl[24] = '{1'b0, 16'h0000, 1'b1, 2'd0, 8'h00, 1'b1, 1'b1, 8'h41, 1'b0};

    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].sl, tbl[i].si, tbl[i].en, tbl[i].mode, tbl[i].lim, tbl[i].rdy);
      tick();
      chk($sformatf("row%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      chk($sformatf("row%0d_data", i), 32'(out_data), 32'(tbl[i].ed));
      chk($sformatf("row%0d_lock", i), 32'(lockup_err), 32'(tbl[i].el));
    end

    // Backpressure: hold for 10 cycles, LFSR keeps stepping underneath.
    drive(1'b1, 16'h0001, 1'b1, 2'd0, 8'h00, 1'b1);
    tick();
    seed_load = 1'b0;
    tick();
    chk("hold_first", 32'(out_data), 32'h01);
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("hold%0d_data", i), 32'(out_data), 32'h01);
      chk($sformatf("hold%0d_valid", i), 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    tick();
    chk("hold_release", 32'(out_data), 32'h2D);

    // Bounded mode, limit 3.
    drive(1'b1, 16'h0001, 1'b1, 2'd1, 8'd3, 1'b1);
    tick();
    seed_load = 1'b0;
    accepted = 0; bad_range = 0; first_valid = 0; saw_reject = 0;
    seen[0] = 0; seen[1] = 0; seen[2] = 0;
    cyc = 0;
    while (accepted < 1000 && cyc < 5000) begin
      tick();
      cyc++;
      if (out_valid) begin
        accepted++;
        first_valid = 1;
        if (out_data > 8'd2) bad_range++;
        else seen[out_data] = seen[out_data] + 1;
      end else if (first_valid != 0) begin
        saw_reject = 1;
      end
    end
    chk("bnd_accepted", 32'(accepted), 32'd1000);
    chk("bnd_range", 32'(bad_range), 32'd0);
    chk("bnd_seen0", 32'(seen[0] > 0), 32'd1);
    chk("bnd_seen1", 32'(seen[1] > 0), 32'd1);
    chk("bnd_seen2", 32'(seen[2] > 0), 32'd1);
    chk("bnd_reject", 32'(saw_reject), 32'd1);

    // Gauss from all-ones state.
    drive(1'b1, 16'hFFFF, 1'b1, 2'd2, 8'h00, 1'b1);
    tick();
    seed_load = 1'b0;
    tick();
    chk("gauss_first", 32'(out_data), 32'd16);

    // Full period from 0001 in gauss mode: each nonzero state seen once.
    drive(1'b1, 16'h0001, 1'b1, 2'd2, 8'h00, 1'b1);
    tick();
    seed_load = 1'b0;
    steps = 0; cnt0 = 0; cnt16 = 0; sum = 0;
    for (int i = 1; i <= 70000; i++) begin
      tick();
      sum += longint'(out_data);
      if (out_data == 8'd0) cnt0++;
      if (out_data == 8'd16) cnt16++;
      if (u_dut.u_core.state_q == 16'h0001) begin
        steps = i;
        break;
      end
    end
    chk("period", 32'(steps), 32'd65535);
    chk("gauss_cnt0", 32'(cnt0 <= 1), 32'd1);
    chk("gauss_cnt16", 32'(cnt16 <= 1), 32'd1);
    chk("gauss_sum", 32'(sum), 32'd524288);

    // Lock-up recovery.
    u_dut.u_core.state_q = 16'h0000;
    tick();
    chk("lock_state", 32'(u_dut.u_core.state_q), 32'h0001);
    chk("lock_err", 32'(lockup_err), 32'd1);
    chk("lock_noload", 32'(out_valid), 32'd0);
    tick();
    chk("lock_sticky", 32'(lockup_err), 32'd1);
    chk("lock_resume", 32'(out_data), 32'd1);
    seed_load = 1'b1;
    seed_in = 16'h1234;
    tick();
    chk("lock_clear", 32'(lockup_err), 32'd0);
    chk("seed_state", 32'(u_dut.u_core.state_q), 32'h1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
